// File: rtl/ta_drrip_repl.sv
// rtl/ta_drrip_repl.sv - thread-aware DRRIP replacement-state engine
// Holds per-set RRPVs and per-thread PSELs; returns one victim per accepted miss.
module ta_drrip_repl #(
  parameter int NUM_WAYS        = 4,
  parameter int NUM_SETS        = 64,
  parameter int RRPV_BITS       = 2,
  parameter int NUM_THREADS     = 2,
  parameter int PSEL_BITS       = 10,
  parameter int BIP_PERIOD      = 32,
  parameter int LEADER_STRIDE   = 16,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  localparam int THREAD_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int WAY_W          = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid,
  input  logic [THREAD_W-1:0]              thread_id,
  input  logic [SET_INDEX_WIDTH-1:0]       set_index,
  input  logic [WAY_W-1:0]                 access_way,
  input  logic                             hit,
  input  logic                             miss,
  output logic                             ready,
  output logic [WAY_W-1:0]                 victim_way,
  output logic                             victim_ready,
  output logic [NUM_THREADS*PSEL_BITS-1:0] psel_counter,
  output logic [NUM_THREADS-1:0]           policy_srrip
);

  localparam int BIP_W = (BIP_PERIOD > 1) ? $clog2(BIP_PERIOD) : 1;
  localparam logic [RRPV_BITS-1:0] RRPV_MAX  = '1;
  localparam logic [RRPV_BITS-1:0] RRPV_LONG = RRPV_MAX - RRPV_BITS'(1);
  localparam logic [PSEL_BITS-1:0] PSEL_MAX  = '1;
  localparam logic [PSEL_BITS-1:0] PSEL_INIT = {1'b1, {(PSEL_BITS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SEARCH, AGE, INSERT} state_t;

  state_t                     state, state_nxt;
  logic [RRPV_BITS-1:0]       rrpv [NUM_SETS][NUM_WAYS];
  logic [PSEL_BITS-1:0]       psel [NUM_THREADS];
  logic [BIP_W-1:0]           bip_counter;
  logic [SET_INDEX_WIDTH-1:0] lat_set;
  logic                       lat_srrip;

  logic                 hit_acc, miss_acc;
  logic                 is_srrip_leader, is_bip_leader, req_srrip;
  logic                 found_max, found_pre;
  logic [WAY_W-1:0]     max_way, pre_way;
  logic [RRPV_BITS-1:0] ins_val;
  int                   leader_mod;

  assign ready        = (state == IDLE);
  assign victim_ready = (state == INSERT);

  always_comb begin
    psel_counter = '0;
    policy_srrip = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      psel_counter[t*PSEL_BITS +: PSEL_BITS] = psel[t];
      policy_srrip[t] = ~psel[t][PSEL_BITS-1];
    end
  end

  always_comb begin
    hit_acc  = valid & ready & hit & ~miss & (int'(access_way) < NUM_WAYS);
    miss_acc = valid & ready & miss & ~hit;
    leader_mod      = int'(set_index) % LEADER_STRIDE;
    is_srrip_leader = (leader_mod == 2 * int'(thread_id));
    is_bip_leader   = (leader_mod == 2 * int'(thread_id) + 1);
    if (is_srrip_leader)    req_srrip = 1'b1;
    else if (is_bip_leader) req_srrip = 1'b0;
    else                    req_srrip = policy_srrip[thread_id];
  end

  // Descending scan so the lowest matching way wins. A way at MAX-1 is the one
  // that reaches MAX in the current aging round, so AGE can pick it directly.
  always_comb begin
    found_max = 1'b0;
    found_pre = 1'b0;
    max_way   = '0;
    pre_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rrpv[lat_set][w] == RRPV_MAX) begin
        found_max = 1'b1;
        max_way   = WAY_W'(w);
      end
      if (rrpv[lat_set][w] == RRPV_LONG) begin
        found_pre = 1'b1;
        pre_way   = WAY_W'(w);
      end
    end
    ins_val = (lat_srrip || bip_counter == '0) ? RRPV_LONG : RRPV_MAX;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (miss_acc) state_nxt = SEARCH;
      SEARCH:  state_nxt = found_max ? INSERT : AGE;
      AGE:     state_nxt = found_pre ? INSERT : AGE;
      INSERT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      lat_set    <= '0;
      lat_srrip  <= 1'b0;
      victim_way <= '0;
    end else begin
      state <= state_nxt;
      if (miss_acc) begin
        lat_set   <= set_index;
        lat_srrip <= req_srrip;
      end
      if (state == SEARCH && found_max) victim_way <= max_way;
      if (state == AGE && found_pre)    victim_way <= pre_way;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          rrpv[s][w] <= RRPV_MAX;
    end else begin
      case (state)
        IDLE:   if (hit_acc) rrpv[set_index][access_way] <= '0;
        AGE:    for (int w = 0; w < NUM_WAYS; w++)
                  rrpv[lat_set][w] <= rrpv[lat_set][w] + RRPV_BITS'(1);
        INSERT: rrpv[lat_set][victim_way] <= ins_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++) psel[t] <= PSEL_INIT;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (miss_acc && int'(thread_id) == t) begin
          if (is_srrip_leader && psel[t] != PSEL_MAX)
            psel[t] <= psel[t] + PSEL_BITS'(1);
          else if (is_bip_leader && psel[t] != '0)
            psel[t] <= psel[t] - PSEL_BITS'(1);
        end
      end
    end
  end

  // Shared BIP throttle: advances on every BIP-policy insertion from any thread.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bip_counter <= '0;
    end else if (state == INSERT && !lat_srrip) begin
      if (int'(bip_counter) == BIP_PERIOD - 1) bip_counter <= '0;
      else                                     bip_counter <= bip_counter + BIP_W'(1);
    end
  end

endmodule

// File: tb/tb_ta_drrip_repl.sv
// tb/tb_ta_drrip_repl.sv - directed table-driven bench for ta_drrip_repl
// Instance dut uses default parameters; dut_s uses PSEL_BITS=4, BIP_PERIOD=4.
module tb_ta_drrip_repl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       valid_a, hit_a, miss_a, ready_a, vr_a;
  logic [0:0] thread_a;
  logic [5:0] set_a;
  logic [1:0] way_a, vw_a, pol_a;
  logic [19:0] psel_a;

  logic       valid_b, hit_b, miss_b, ready_b, vr_b;
  logic [0:0] thread_b;
  logic [5:0] set_b;
  logic [1:0] way_b, vw_b, pol_b;
  logic [7:0] psel_b;

  ta_drrip_repl dut (
    .clk(clk), .rst(rst), .valid(valid_a), .thread_id(thread_a), .set_index(set_a),
    .access_way(way_a), .hit(hit_a), .miss(miss_a), .ready(ready_a),
    .victim_way(vw_a), .victim_ready(vr_a), .psel_counter(psel_a), .policy_srrip(pol_a)
  );

  ta_drrip_repl #(.PSEL_BITS(4), .BIP_PERIOD(4)) dut_s (
    .clk(clk), .rst(rst), .valid(valid_b), .thread_id(thread_b), .set_index(set_b),
    .access_way(way_b), .hit(hit_b), .miss(miss_b), .ready(ready_b),
    .victim_way(vw_b), .victim_ready(vr_b), .psel_counter(psel_b), .policy_srrip(pol_b)
  );

  typedef struct {
    bit sel;
    bit is_miss;
    int thread;
    int set;
    int way;
    int exp_victim;
    int exp_lat;
    int exp_val;
    int exp_psel0;
    int exp_psel1;
    int exp_bip;
    int exp_pol;
  } vec_t;

  vec_t vecs_a[$];
  vec_t vecs_b[$];
  int errors = 0;
  int checks = 0;

  int b_bip_vic[5] = '{0, 1, 1, 1, 1};
  int b_bip_val[5] = '{2, 3, 3, 3, 2};
  int b_bip_cnt[5] = '{1, 2, 3, 0, 1};
  int b_ps_vic[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
  int b_ps_val[9]  = '{3, 3, 3, 2, 3, 3, 3, 2, 3};
  int b_ps_p0[9]   = '{7, 6, 5, 4, 3, 2, 1, 0, 0};
  int b_ps_cnt[9]  = '{2, 3, 0, 1, 2, 3, 0, 1, 2};

  function automatic vec_t mk(bit sel, bit m, int thr, int s, int w, int vic, int lat,
                              int val, int p0, int p1, int bip, int pol);
    vec_t v;
    v.sel = sel; v.is_miss = m; v.thread = thr; v.set = s; v.way = w;
    v.exp_victim = vic; v.exp_lat = lat; v.exp_val = val;
    v.exp_psel0 = p0; v.exp_psel1 = p1; v.exp_bip = bip; v.exp_pol = pol;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rrpv_of(bit sel, int s, int w);
    return sel ? int'(dut_s.rrpv[s][w]) : int'(dut.rrpv[s][w]);
  endfunction
  function automatic int bip_of(bit sel);
    return sel ? int'(dut_s.bip_counter) : int'(dut.bip_counter);
  endfunction
  function automatic int psel0_of(bit sel);
    return sel ? int'(psel_b[3:0]) : int'(psel_a[9:0]);
  endfunction
  function automatic int psel1_of(bit sel);
    return sel ? int'(psel_b[7:4]) : int'(psel_a[19:10]);
  endfunction
  function automatic int non_max_count();
    int n = 0;
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 4; w++) begin
        if (dut.rrpv[s][w] != 2'd3)   n++;
        if (dut_s.rrpv[s][w] != 2'd3) n++;
      end
    return n;
  endfunction

  task automatic drive(bit sel, bit v, bit h, bit m, int thr, int s, int w);
    if (sel) begin
      valid_b = v; hit_b = h; miss_b = m;
      thread_b = 1'(thr); set_b = 6'(s); way_b = 2'(w);
    end else begin
      valid_a = v; hit_a = h; miss_a = m;
      thread_a = 1'(thr); set_a = 6'(s); way_a = 2'(w);
    end
  endtask

  // Every call starts and ends on a falling edge so hit records run back-to-back.
  task automatic apply(input vec_t v, input int idx);
    int lat;
    drive(v.sel, 1'b1, !v.is_miss, v.is_miss, v.thread, v.set, v.way);
    @(negedge clk);
    drive(v.sel, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    if (!v.is_miss) begin
      check($sformatf("v%0d.%0d hit_rrpv", v.sel, idx), rrpv_of(v.sel, v.set, v.way), 0);
      check($sformatf("v%0d.%0d hit_ready", v.sel, idx), v.sel ? ready_b : ready_a, 1);
    end else begin
      lat = 1;
      while (!(v.sel ? vr_b : vr_a) && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("v%0d.%0d latency", v.sel, idx), lat, v.exp_lat);
      check($sformatf("v%0d.%0d victim", v.sel, idx), v.sel ? vw_b : vw_a, v.exp_victim);
      @(negedge clk);
      check($sformatf("v%0d.%0d ins_rrpv", v.sel, idx),
            rrpv_of(v.sel, v.set, v.exp_victim), v.exp_val);
      check($sformatf("v%0d.%0d ready", v.sel, idx), v.sel ? ready_b : ready_a, 1);
    end
    check($sformatf("v%0d.%0d psel0", v.sel, idx), psel0_of(v.sel), v.exp_psel0);
    check($sformatf("v%0d.%0d psel1", v.sel, idx), psel1_of(v.sel), v.exp_psel1);
    check($sformatf("v%0d.%0d bip", v.sel, idx), bip_of(v.sel), v.exp_bip);
    check($sformatf("v%0d.%0d policy", v.sel, idx), v.sel ? pol_b : pol_a, v.exp_pol);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    vecs_a.push_back(mk(0, 1, 0, 0, 0, 0, 2, 2, 513, 512, 0, 0));
    vecs_a.push_back(mk(0, 0, 0, 5, 1, 0, 0, 0, 513, 512, 0, 0));
    vecs_a.push_back(mk(0, 1, 0, 5, 0, 0, 2, 2, 513, 512, 1, 0));
    for (int w = 0; w < 4; w++)
      vecs_a.push_back(mk(0, 0, 0, 6, w, 0, 0, 0, 513, 512, 1, 0));
    vecs_a.push_back(mk(0, 1, 1, 6, 0, 0, 5, 3, 513, 512, 2, 0));
    vecs_a.push_back(mk(0, 1, 0, 1, 0, 0, 2, 3, 512, 512, 3, 0));
    vecs_a.push_back(mk(0, 1, 1, 2, 0, 0, 2, 2, 512, 513, 3, 0));
    vecs_a.push_back(mk(0, 1, 1, 0, 0, 1, 2, 3, 512, 513, 4, 0));
    vecs_a.push_back(mk(0, 1, 0, 0, 0, 1, 2, 2, 513, 513, 4, 0));
    for (int i = 0; i < 5; i++)
      vecs_b.push_back(mk(1, 1, 1, 5, 0, b_bip_vic[i], 2, b_bip_val[i], 8, 8, b_bip_cnt[i], 0));
    for (int i = 0; i < 9; i++)
      vecs_b.push_back(mk(1, 1, 0, 1, 0, b_ps_vic[i], 2, b_ps_val[i], b_ps_p0[i], 8, b_ps_cnt[i], 1));
    vecs_b.push_back(mk(1, 1, 0, 4, 0, 0, 2, 2, 0, 8, 2, 1));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ready", ready_a, 1);
    check("reset victim_ready", vr_a, 0);
    check("reset victim_way", vw_a, 0);
    check("reset psel_a", int'(psel_a), 32'h80200);
    check("reset psel_b", int'(psel_b), 32'h88);
    check("reset policy", pol_a, 0);
    check("reset bip", bip_of(0), 0);
    check("reset rrpv", non_max_count(), 0);

    for (int i = 0; i < vecs_a.size(); i++) apply(vecs_a[i], i);
    check("set5 way1 after miss", rrpv_of(0, 5, 1), 0);
    for (int w = 1; w < 4; w++) check($sformatf("set6 way%0d aged", w), rrpv_of(0, 6, w), 3);

    // Hit offered while busy in SEARCH must be dropped.
    drive(0, 1, 0, 1, 0, 8, 0);
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 5, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("busy victim_ready", vr_a, 1);
    check("busy victim_way", vw_a, 0);
    @(negedge clk);
    check("busy hit ignored", rrpv_of(0, 5, 0), 2);
    check("busy bip", bip_of(0), 5);

    // Simultaneous hit and miss must be dropped.
    drive(0, 1, 1, 1, 0, 1, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("hm ready", ready_a, 1);
    check("hm victim_ready", vr_a, 0);
    @(negedge clk);
    check("hm victim_ready2", vr_a, 0);
    check("hm rrpv", rrpv_of(0, 1, 0), 3);
    check("hm psel0", psel0_of(0), 513);

    // Reset asserted mid-AGE discards the miss.
    for (int w = 0; w < 4; w++) begin
      drive(0, 1, 1, 0, 0, 7, w);
      @(negedge clk);
    end
    drive(0, 1, 0, 1, 0, 7, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("age busy", ready_a, 0);
    rst = 1'b1;
    #1;
    check("async reset ready", ready_a, 1);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (vr_a) pulses++;
    end
    check("age reset no pulse", pulses, 0);
    check("age reset rrpv", non_max_count(), 0);
    check("age reset ready", ready_a, 1);
    check("age reset psel", int'(psel_a), 32'h80200);
    check("age reset bip", bip_of(0), 0);

    for (int i = 0; i < vecs_b.size(); i++) apply(vecs_b[i], i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
